vector_ex_stage: RTL and testbench

VECTOR_EX_STAGE -- requirements
Module: vector_ex_stage

---
 rtl/vector_ex_stage_if.sv | 68 ++++++
 rtl/vector_ex_stage.sv | 168 ++++++++++++++++
 tb/tb_vector_ex_stage.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/vector_ex_stage_if.sv
// Decode-to-execute bus of the vector EX stage: operands and controls in, lane results out.
// The slave modport is the EX stage itself; the master modport is the decode side.
interface vector_ex_stage_if;
  logic        wr_pxl;
  logic        wr_pos;
  logic        wr_mul_reg;
  logic        wr_wom;
  logic        wr_mul_pos_in;
  logic        alu_func;
  logic [31:0] pix_in1;
  logic [31:0] pix_in2;
  logic [31:0] pix_in3;
  logic [31:0] pix_in4;
  logic [31:0] cte_in1;
  logic [31:0] cte_in2;
  logic [31:0] cte_in3;
  logic [31:0] cte_in4;
  logic [31:0] mul_in1;
  logic [31:0] mul_in2;
  logic [31:0] mul_in3;
  logic [31:0] mul_in4;
  logic [31:0] mul_in5;
  logic [31:0] mul_in6;
  logic [31:0] mul_in7;
  logic [31:0] mul_in8;
  logic [31:0] i;
  logic [31:0] j;
  logic [31:0] n;
  logic [31:0] wom_addr;

  logic        stall;
  logic        res_valid;
  logic [31:0] res1;
  logic [31:0] res2;
  logic [31:0] res3;
  logic [31:0] res4;
  logic        wr_pxl_q;
  logic        wr_pos_q;
  logic        wr_mul_reg_q;
  logic        wr_wom_q;
  logic        wr_mul_pos_q;
  logic [31:0] i_q;
  logic [31:0] j_q;
  logic [31:0] n_q;
  logic [31:0] wom_addr_q;

  modport slave (
    input  wr_pxl, wr_pos, wr_mul_reg, wr_wom, wr_mul_pos_in, alu_func,
    input  pix_in1, pix_in2, pix_in3, pix_in4,
    input  cte_in1, cte_in2, cte_in3, cte_in4,
    input  mul_in1, mul_in2, mul_in3, mul_in4, mul_in5, mul_in6, mul_in7, mul_in8,
    input  i, j, n, wom_addr,
    output stall, res_valid, res1, res2, res3, res4,
    output wr_pxl_q, wr_pos_q, wr_mul_reg_q, wr_wom_q, wr_mul_pos_q,
    output i_q, j_q, n_q, wom_addr_q
  );

  modport master (
    output wr_pxl, wr_pos, wr_mul_reg, wr_wom, wr_mul_pos_in, alu_func,
    output pix_in1, pix_in2, pix_in3, pix_in4,
    output cte_in1, cte_in2, cte_in3, cte_in4,
    output mul_in1, mul_in2, mul_in3, mul_in4, mul_in5, mul_in6, mul_in7, mul_in8,
    output i, j, n, wom_addr,
    input  stall, res_valid, res1, res2, res3, res4,
    input  wr_pxl_q, wr_pos_q, wr_mul_reg_q, wr_wom_q, wr_mul_pos_q,
    input  i_q, j_q, n_q, wom_addr_q
  );
endinterface

// File: rtl/vector_ex_stage.sv
// Four-lane vector execute stage: single-cycle add, two-cycle multiply with a one-cycle stall.
// Optional macro VEX_ADD_SATURATE_EN clamps each add lane to 255; otherwise adds wrap modulo 2^32.
module vector_ex_stage (
  input logic              clk,
  input logic              rst,
  vector_ex_stage_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, MUL2 = 1'b1} state_t;

  state_t state;
  state_t state_next;

  logic [3:0][31:0] pix;
  logic [3:0][31:0] cte;
  logic [3:0][31:0] mul_a;
  logic [3:0][31:0] mul_b;
  logic [3:0][31:0] lane_sum;
  logic [3:0][31:0] lane_prod;
  logic [3:0][31:0] pp_ll_next;
  logic [3:0][15:0] pp_cross_next;
  logic [3:0][31:0] pp_ll;
  logic [3:0][15:0] pp_cross;
  logic [4:0]       ctrl_dec;
  logic [4:0]       ctrl_hold;
  logic [31:0]      i_hold;
  logic [31:0]      j_hold;
  logic [31:0]      n_hold;
  logic [31:0]      wom_hold;

  logic [3:0][31:0] res_q;
  logic [4:0]       ctrl_q;
  logic [31:0]      i_reg;
  logic [31:0]      j_reg;
  logic [31:0]      n_reg;
  logic [31:0]      wom_reg;
  logic             res_valid_q;

  logic load_add;
  logic load_mul;
  logic finish_mul;
  logic stall_now;

  assign pix      = {bus.pix_in4, bus.pix_in3, bus.pix_in2, bus.pix_in1};
  assign cte      = {bus.cte_in4, bus.cte_in3, bus.cte_in2, bus.cte_in1};
  assign mul_a    = {bus.mul_in7, bus.mul_in5, bus.mul_in3, bus.mul_in1};
  assign mul_b    = {bus.mul_in8, bus.mul_in6, bus.mul_in4, bus.mul_in2};
  assign ctrl_dec = {bus.wr_pxl, bus.wr_pos, bus.wr_mul_reg, bus.wr_wom, bus.wr_mul_pos_in};

  // The multiply is split into 16x16 partial products: the first cycle forms lo*lo and the
  // low half of the cross terms, the second cycle adds them; only the low 32 bits survive.
  for (genvar k = 0; k < 4; k++) begin : g_lane
`ifdef VEX_ADD_SATURATE_EN
    logic [32:0] sum_full;
    assign sum_full    = {1'b0, pix[k]} + {1'b0, cte[k]};
    assign lane_sum[k] = (sum_full > 33'd255) ? 32'd255 : sum_full[31:0];
`else
    assign lane_sum[k] = pix[k] + cte[k];
`endif
    assign pp_ll_next[k]    = {16'd0, mul_a[k][15:0]} * {16'd0, mul_b[k][15:0]};
    assign pp_cross_next[k] = mul_a[k][15:0] * mul_b[k][31:16] + mul_a[k][31:16] * mul_b[k][15:0];
    assign lane_prod[k]     = pp_ll[k] + {pp_cross[k], 16'h0000};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.alu_func) state_next = MUL2;
      MUL2:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall_now  = 1'b0;
    load_add   = 1'b0;
    load_mul   = 1'b0;
    finish_mul = 1'b0;
    case (state)
      IDLE: begin
        if (bus.alu_func) load_mul = 1'b1;
        else              load_add = 1'b1;
      end
      MUL2: begin
        stall_now  = 1'b1;
        finish_mul = 1'b1;
      end
      default: ;
    endcase
  end

  // Multiply capture stage; cleared by reset so an aborted multiply leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pp_ll     <= '0;
      pp_cross  <= '0;
      ctrl_hold <= '0;
      i_hold    <= '0;
      j_hold    <= '0;
      n_hold    <= '0;
      wom_hold  <= '0;
    end else if (load_mul) begin
      pp_ll     <= pp_ll_next;
      pp_cross  <= pp_cross_next;
      ctrl_hold <= ctrl_dec;
      i_hold    <= bus.i;
      j_hold    <= bus.j;
      n_hold    <= bus.n;
      wom_hold  <= bus.wom_addr;
    end
  end

  // Result registers only move when an operation completes, so they hold through MUL2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q       <= '0;
      ctrl_q      <= '0;
      i_reg       <= '0;
      j_reg       <= '0;
      n_reg       <= '0;
      wom_reg     <= '0;
      res_valid_q <= 1'b0;
    end else if (load_add) begin
      res_q       <= lane_sum;
      ctrl_q      <= ctrl_dec;
      i_reg       <= bus.i;
      j_reg       <= bus.j;
      n_reg       <= bus.n;
      wom_reg     <= bus.wom_addr;
      res_valid_q <= 1'b1;
    end else if (finish_mul) begin
      res_q       <= lane_prod;
      ctrl_q      <= ctrl_hold;
      i_reg       <= i_hold;
      j_reg       <= j_hold;
      n_reg       <= n_hold;
      wom_reg     <= wom_hold;
      res_valid_q <= 1'b1;
    end else begin
      res_valid_q <= 1'b0;
    end
  end

  assign bus.stall        = stall_now;
  assign bus.res_valid    = res_valid_q;
  assign bus.res1         = res_q[0];
  assign bus.res2         = res_q[1];
  assign bus.res3         = res_q[2];
  assign bus.res4         = res_q[3];
  assign bus.wr_pxl_q     = ctrl_q[4];
  assign bus.wr_pos_q     = ctrl_q[3];
  assign bus.wr_mul_reg_q = ctrl_q[2];
  assign bus.wr_wom_q     = ctrl_q[1];
  assign bus.wr_mul_pos_q = ctrl_q[0];
  assign bus.i_q          = i_reg;
  assign bus.j_q          = j_reg;
  assign bus.n_q          = n_reg;
  assign bus.wom_addr_q   = wom_reg;

endmodule

// File: tb/tb_vector_ex_stage.sv
// Scoreboard bench for vector_ex_stage: expected results queued at issue, compared on res_valid.
module tb_vector_ex_stage;

  typedef struct packed {
    logic [3:0][31:0] res;
    logic [4:0]       ctrl;
    logic [31:0]      i;
    logic [31:0]      j;
    logic [31:0]      n;
    logic [31:0]      wom;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_compared   = 0;
  int   n_mismatched = 0;
  exp_t sb[$];
  exp_t last_pushed = '0;
  exp_t held        = '0;

  vector_ex_stage_if bus ();

  vector_ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one instruction and queues its reference result; does not wait for any edge.
  task automatic driveOp(input logic func, input logic [4:0] ctrl,
                         input logic [3:0][31:0] pix, input logic [3:0][31:0] cte,
                         input logic [7:0][31:0] mul,
                         input logic [31:0] pi, input logic [31:0] pj,
                         input logic [31:0] pn, input logic [31:0] pw);
    exp_t        e;
    logic [32:0] s;
    logic [63:0] p;
    bus.alu_func      = func;
    {bus.wr_pxl, bus.wr_pos, bus.wr_mul_reg, bus.wr_wom, bus.wr_mul_pos_in} = ctrl;
    {bus.pix_in4, bus.pix_in3, bus.pix_in2, bus.pix_in1} = pix;
    {bus.cte_in4, bus.cte_in3, bus.cte_in2, bus.cte_in1} = cte;
    {bus.mul_in8, bus.mul_in7, bus.mul_in6, bus.mul_in5,
     bus.mul_in4, bus.mul_in3, bus.mul_in2, bus.mul_in1} = mul;
    bus.i = pi; bus.j = pj; bus.n = pn; bus.wom_addr = pw;
    e.ctrl = ctrl; e.i = pi; e.j = pj; e.n = pn; e.wom = pw;
    for (int k = 0; k < 4; k++) begin
      if (!func) begin
        s = {1'b0, pix[k]} + {1'b0, cte[k]};
`ifdef VEX_ADD_SATURATE_EN
        e.res[k] = (s > 33'd255) ? 32'd255 : s[31:0];
`else
        e.res[k] = s[31:0];
`endif
      end else begin
        p = {32'd0, mul[2*k]} * {32'd0, mul[2*k+1]};
        e.res[k] = p[31:0];
      end
    end
    held        = last_pushed;
    last_pushed = e;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic func, input logic [4:0] ctrl,
                               input logic [3:0][31:0] pix, input logic [3:0][31:0] cte,
                               input logic [7:0][31:0] mul,
                               input logic [31:0] pi, input logic [31:0] pj,
                               input logic [31:0] pn, input logic [31:0] pw);
    driveOp(func, ctrl, pix, cte, mul, pi, pj, pn, pw);
    step();
    if (bus.stall) step();
  endtask

  // Every completed operation must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.res_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_res_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("res1", bus.res1, e.res[0]);
        checkOutput("res2", bus.res2, e.res[1]);
        checkOutput("res3", bus.res3, e.res[2]);
        checkOutput("res4", bus.res4, e.res[3]);
        checkOutput("ctrl_q", {27'd0, bus.wr_pxl_q, bus.wr_pos_q, bus.wr_mul_reg_q,
                               bus.wr_wom_q, bus.wr_mul_pos_q}, {27'd0, e.ctrl});
        checkOutput("i_q", bus.i_q, e.i);
        checkOutput("j_q", bus.j_q, e.j);
        checkOutput("n_q", bus.n_q, e.n);
        checkOutput("wom_addr_q", bus.wom_addr_q, e.wom);
        checkOutput("no_stall_with_valid", {31'd0, bus.stall}, 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0][31:0] rp;
    logic [3:0][31:0] rc;
    logic [7:0][31:0] rm;
    logic             rf;

    rst = 1'b1;
    bus.alu_func = 1'b0;
    {bus.wr_pxl, bus.wr_pos, bus.wr_mul_reg, bus.wr_wom, bus.wr_mul_pos_in} = 5'b11111;
    {bus.pix_in4, bus.pix_in3, bus.pix_in2, bus.pix_in1} = {4{32'h1234}};
    {bus.cte_in4, bus.cte_in3, bus.cte_in2, bus.cte_in1} = {4{32'h1}};
    {bus.mul_in8, bus.mul_in7, bus.mul_in6, bus.mul_in5,
     bus.mul_in4, bus.mul_in3, bus.mul_in2, bus.mul_in1} = {8{32'h3}};
    bus.i = 32'h11; bus.j = 32'h22; bus.n = 32'h33; bus.wom_addr = 32'h44;
    #22;
    checkOutput("reset_res1", bus.res1, 32'd0);
    checkOutput("reset_res4", bus.res4, 32'd0);
    checkOutput("reset_res_valid", {31'd0, bus.res_valid}, 32'd0);
    checkOutput("reset_stall", {31'd0, bus.stall}, 32'd0);
    checkOutput("reset_wr_pxl_q", {31'd0, bus.wr_pxl_q}, 32'd0);
    checkOutput("reset_i_q", bus.i_q, 32'd0);
    checkOutput("reset_wom_addr_q", bus.wom_addr_q, 32'd0);

    @(posedge clk); #1;
    rst = 1'b0;

    // Basic add, accepted on the first edge after reset.
    driveOp(1'b0, 5'b10101, {32'd40, 32'd30, 32'd20, 32'd10}, {32'd4, 32'd3, 32'd2, 32'd1},
            '0, 32'd1, 32'd2, 32'd3, 32'd4);
    step();
    checkOutput("add_res_valid", {31'd0, bus.res_valid}, 32'd1);
    checkOutput("add_stall", {31'd0, bus.stall}, 32'd0);

    // Saturation boundary and 32-bit wrap.
    applyStimulus(1'b0, 5'b01010, {32'd0, 32'd255, 32'd256, 32'd200},
                  {32'd255, 32'd0, 32'd0, 32'd100}, '0, 32'd5, 32'd6, 32'd7, 32'd8);
    applyStimulus(1'b0, 5'b00001, {32'd1, 32'd1, 32'd1, 32'hFFFFFFFF},
                  {32'd1, 32'd1, 32'd1, 32'd2}, '0, 32'd9, 32'd10, 32'd11, 32'd12);

    // Multiply with the low-32-bit truncation case; results hold during the stall cycle.
    driveOp(1'b1, 5'b11000, '0, '0,
            {32'd0, 32'd7, 32'h10000, 32'h10000, 32'd6, 32'd5, 32'd4, 32'd3},
            32'hA, 32'hB, 32'hC, 32'hD);
    step();
    checkOutput("mul_stall", {31'd0, bus.stall}, 32'd1);
    checkOutput("mul2_res_valid", {31'd0, bus.res_valid}, 32'd0);
    checkOutput("mul2_hold_res1", bus.res1, held.res[0]);
    checkOutput("mul2_hold_i_q", bus.i_q, held.i);
    step();
    checkOutput("mul_done_stall", {31'd0, bus.stall}, 32'd0);
    checkOutput("mul_done_res_valid", {31'd0, bus.res_valid}, 32'd1);

    // Back-to-back multiply, multiply, add: valid at cycles 2,4,5 and stall at 1,3.
    driveOp(1'b1, 5'b00100, '0, '0, {32'd9, 32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2},
            32'd1, 32'd1, 32'd1, 32'd1);
    step();
    checkOutput("b2b_c1_stall", {31'd0, bus.stall}, 32'd1);
    checkOutput("b2b_c1_valid", {31'd0, bus.res_valid}, 32'd0);
    step();
    checkOutput("b2b_c2_stall", {31'd0, bus.stall}, 32'd0);
    checkOutput("b2b_c2_valid", {31'd0, bus.res_valid}, 32'd1);
    driveOp(1'b1, 5'b00010, '0, '0,
            {32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'h9ABCDEF0, 32'd0, 32'd1, 32'd1, 32'd1},
            32'd2, 32'd2, 32'd2, 32'd2);
    step();
    checkOutput("b2b_c3_stall", {31'd0, bus.stall}, 32'd1);
    checkOutput("b2b_c3_valid", {31'd0, bus.res_valid}, 32'd0);
    step();
    checkOutput("b2b_c4_stall", {31'd0, bus.stall}, 32'd0);
    checkOutput("b2b_c4_valid", {31'd0, bus.res_valid}, 32'd1);
    driveOp(1'b0, 5'b10000, {32'd1, 32'd2, 32'd3, 32'd4}, {32'd5, 32'd6, 32'd7, 32'd8}, '0,
            32'd3, 32'd3, 32'd3, 32'd3);
    step();
    checkOutput("b2b_c5_stall", {31'd0, bus.stall}, 32'd0);
    checkOutput("b2b_c5_valid", {31'd0, bus.res_valid}, 32'd1);

    // Random mix of adds and multiplies, half of them near the saturation range.
    for (int t = 0; t < 24; t++) begin
      rf = 1'($urandom_range(0, 1));
      for (int k = 0; k < 4; k++) begin
        rp[k] = (t % 2 == 0) ? $urandom_range(0, 300) : $urandom();
        rc[k] = (t % 2 == 0) ? $urandom_range(0, 300) : $urandom();
      end
      for (int k = 0; k < 8; k++) rm[k] = $urandom();
      applyStimulus(rf, 5'($urandom_range(0, 31)), rp, rc, rm,
                    $urandom(), $urandom(), $urandom(), $urandom());
    end

    // Reset during MUL2 aborts the multiply; an add afterwards completes normally.
    driveOp(1'b1, 5'b11111, '0, '0, {8{32'h00010003}}, 32'h55, 32'h66, 32'h77, 32'h88);
    step();
    checkOutput("abort_stall_before", {31'd0, bus.stall}, 32'd1);
    rst = 1'b1;
    sb.delete();
    #1;
    checkOutput("abort_res1", bus.res1, 32'd0);
    checkOutput("abort_res_valid", {31'd0, bus.res_valid}, 32'd0);
    checkOutput("abort_stall", {31'd0, bus.stall}, 32'd0);
    checkOutput("abort_i_q", bus.i_q, 32'd0);
    step();
    rst = 1'b0;
    driveOp(1'b0, 5'b00011, {32'd7, 32'd7, 32'd7, 32'd7}, {32'd1, 32'd2, 32'd3, 32'd4}, '0,
            32'd20, 32'd21, 32'd22, 32'd23);
    step();
    checkOutput("post_reset_add_valid", {31'd0, bus.res_valid}, 32'd1);

    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
